// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared encodings for the multi-cycle divider
package div_unit_pkg;

  // Divider FSM encodings
  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  // Request and result-ready levels as seen on the ex/divider handshake
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  // Width of the HI/LO result bus
  localparam int DoubleRegBusW = 64;

endpackage

// File: rtl/div_unit.sv
// rtl/div_unit.sv - restoring shift-subtract DIV/DIVU unit beside the ex stage
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signedDiv_i,
  input  logic [DATA_W-1:0]   opNum1_i,
  input  logic [DATA_W-1:0]   opNum2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);

  div_state_e            state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_W-1:0]     dividend_q;   // shifts out dividend bits, shifts in quotient bits
  logic [DATA_W-1:0]     divisor_q;
  logic [DATA_W-1:0]     rem_q;        // partial remainder, always below divisor_q
  logic                  signed_q;
  logic                  sign1_q;
  logic                  sign2_q;
  logic [2*DATA_W-1:0]   result_q;
  logic                  ready_q;

  logic [DATA_W-1:0]     op1_abs;
  logic [DATA_W-1:0]     op2_abs;
  logic [DATA_W:0]       shifted;
  logic [DATA_W:0]       trial;
  logic                  qbit;
  logic [DATA_W-1:0]     rem_d;
  logic [DATA_W-1:0]     quo_d;
  logic [DATA_W-1:0]     quo_fix;
  logic [DATA_W-1:0]     rem_fix;
  logic                  last_iter;

  // Operand magnitudes, one restoring step, and the final sign fix-up
  always_comb begin
    op1_abs   = (signedDiv_i && opNum1_i[DATA_W-1]) ? -opNum1_i : opNum1_i;
    op2_abs   = (signedDiv_i && opNum2_i[DATA_W-1]) ? -opNum2_i : opNum2_i;
    shifted   = {rem_q, dividend_q[DATA_W-1]};
    trial     = shifted - {1'b0, divisor_q};
    qbit      = ~trial[DATA_W];
    rem_d     = qbit ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
    quo_d     = {dividend_q[DATA_W-2:0], qbit};
    // Quotient is negative when operand signs differ; remainder follows the dividend.
    // 0x80000000 / -1 falls out as 0x80000000 since both magnitudes wrap identically.
    quo_fix   = (signed_q && (sign1_q ^ sign2_q)) ? -quo_d : quo_d;
    rem_fix   = (signed_q && sign1_q) ? -rem_d : rem_d;
    last_iter = (cnt_q == CNT_W'(DATA_W - 1));
  end

  // Divider FSM with registered result and ready
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= DivFree;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      signed_q   <= 1'b0;
      sign1_q    <= 1'b0;
      sign2_q    <= 1'b0;
      result_q   <= '0;
      ready_q    <= DivResultNotReady;
    end else begin
      case (state_q)
        DivFree: begin
          result_q <= '0;
          ready_q  <= DivResultNotReady;
          // annul_i wins over a simultaneous request
          if (start_i == DivStart && !annul_i) begin
            if (opNum2_i == '0) begin
              state_q <= DivByZero;
            end else begin
              state_q    <= DivOn;
              dividend_q <= op1_abs;
              divisor_q  <= op2_abs;
              rem_q      <= '0;
              signed_q   <= signedDiv_i;
              sign1_q    <= opNum1_i[DATA_W-1];
              sign2_q    <= opNum2_i[DATA_W-1];
              cnt_q      <= '0;
            end
          end
        end
        DivByZero: begin
          state_q  <= DivEnd;
          result_q <= '0;
          ready_q  <= DivResultReady;
        end
        DivOn: begin
          if (annul_i) begin
            state_q  <= DivFree;
            result_q <= '0;
            ready_q  <= DivResultNotReady;
          end else begin
            dividend_q <= quo_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_q + CNT_W'(1);
            if (last_iter) begin
              state_q  <= DivEnd;
              result_q <= {rem_fix, quo_fix};
              ready_q  <= DivResultReady;
            end
          end
        end
        DivEnd: begin
          // Hold the result until ex drops its request for a cycle
          if (start_i == DivStop) begin
            state_q  <= DivFree;
            result_q <= '0;
            ready_q  <= DivResultNotReady;
          end
        end
        default: begin
          state_q <= DivFree;
        end
      endcase
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider for DIV/DIVU, sitting directly beside the ex stage.
- ex issues operands and a start request, then holds until the result is ready.
- The 64-bit result (remainder in the high half, quotient in the low half) is handed back to ex, which forwards it through ex_mem/mem/mem_wb to hilo_reg as HI/LO.
- The algorithm is restoring shift-subtract, one quotient bit per cycle.

Parameters:
- DATA_W, 32, operand width; the result width is 2*DATA_W.
- CNT_W, 6, iteration counter width; must hold DATA_W.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
- signedDiv_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU).
- opNum1_i  input  32  dividend.
- opNum2_i  input  32  divisor.
- start_i  input  1  division request; ex holds it high until ready_o is seen.
- annul_i  input  1  cancel in-flight division (e.g. a future flush).
- result_o  output  64  [63:32] = remainder (HI), [31:0] = quotient (LO).
- ready_o  output  1  result valid.

Behaviour:
- Reset (rst==0 at an edge): state DivFree, counter 0, internal dividend register 0, result_o = 0, ready_o = 0. This applies mid-operation too; any in-flight result is discarded.
- Registered outputs: result_o and ready_o change only on clock edges.
- State machine (2-bit):
  - DivFree:
    - start_i=1 and annul_i=0 and opNum2_i==0: go to DivByZero.
    - start_i=1 and annul_i=0 and opNum2_i!=0: go to DivOn. Latch absolute values of the operands (when signedDiv_i=1 and the operand is negative), latch signedDiv_i and both sign bits, and set counter = 0.
    - Otherwise: stay in DivFree with ready_o = 0 and result_o = 0.
  - DivByZero: next edge go to DivEnd with result_o = 0 and ready_o = 1.
  - DivOn:
    - annul_i=1: go to DivFree, ready_o = 0, result_o = 0.
    - Otherwise, one iteration per edge: form {partial_rem, dividend} shifted left by 1, trial-subtract the divisor (33-bit compare), set quotient bit, increment counter.
    - On the edge that completes iteration 31 (counter==31): go to DivEnd, apply sign correction, drive result_o, set ready_o = 1.
  - DivEnd: hold result_o and ready_o = 1 while start_i=1. When start_i=0: go to DivFree, clear ready_o and result_o.
- Sign correction when signed:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
  - Unsigned mode uses no correction.
- Overflow case 0x80000000 / 0xFFFFFFFF (signed): quotient 0x80000000, remainder 0; no trap.
- Latency: with the start-sampling edge E0, ready_o is high after edge E32 (32 iterations). Divide-by-zero gives ready_o high after E1.
- Simultaneous start_i and annul_i in DivFree: annul wins and the request is ignored.
- start_i asserted in DivEnd: no new operation is accepted until start_i drops for at least one cycle.
- Operand inputs are don't-care after E0; the block uses only latched copies.

Decomposition:
- Add to defines.v:
  - state encodings DivFree 2'b00, DivByZero 2'b01, DivOn 2'b10, DivEnd 2'b11;
  - DivStart/DivStop (1'b1/1'b0) and DivResultReady/DivResultNotReady;
  - DoubleRegBus 63:0.
- No sub-module is warranted: the FSM, datapath and sign fix-up fit one module of about 150–200 lines.

Test Plan:
- Unsigned 100 / 7 (signedDiv_i=0, start held): ready_o rises exactly after E32; result_o = 0x00000002_0000000E; ready_o and result_o clear one edge after start_i drops.
- Signed −7 / 2 (0xFFFFFFF9 / 0x00000002): result_o = 0xFFFFFFFF_FFFFFFFD (remainder −1, quotient −3). Also 7 / −2 gives 0x00000001_FFFFFFFD.
- Divide by zero, 5 / 0: ready_o = 1 after E1; result_o = 0x0; the next request after start_i drops completes normally.
- Signed 0x80000000 / 0xFFFFFFFF gives 0x00000000_80000000. Unsigned 0xFFFFFFFF / 0x00000001 gives 0x00000000_FFFFFFFF.
- Annul: assert annul_i for one cycle at iteration 10 → ready_o never rises and state returns to DivFree. A follow-up 9 / 3 yields 0x00000000_00000003 after 32 cycles.
- Reset: drive rst=0 for one edge during iteration 15 → result_o = 0, ready_o = 0, DivFree. Operands presented with start_i after release complete with correct latency.
